// File: rtl/dff_mem_burst.sv
// Flip-flop RAM with a command channel and write/read beat streams.
// A command starts a burst at a start address. The address auto-increments
// and wraps at DEPTH. Read data is registered and is held stable under backpressure.
module dff_mem_burst #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit so that DEPTH itself is representable for the range check
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next, ptr_inc;
    logic [LEN_W-1:0]    cnt_reg, cnt_next;
    logic                rd_valid_reg, rd_valid_next;
    logic [DATA_W-1:0]   rd_data_reg;
    logic                err_reg, err_next;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic cmd_fire, addr_ok, wr_fire, rd_issue;

    assign cmd_ready = (state_reg == IDLE);
    assign wr_ready  = (state_reg == WRITE);
    assign busy      = (state_reg != IDLE);
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign err       = err_reg;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign addr_ok  = ({1'b0, cmd_addr} < DEPTH_EXT);
    assign wr_fire  = wr_valid && wr_ready;
    // Issue a read when the output register is empty or being drained this cycle
    assign rd_issue = (state_reg == READ) && (!rd_valid_reg || rd_ready);
    assign ptr_inc  = (ptr_reg == LAST_ADDR) ? '0 : ptr_reg + 1'b1;

    // Next-state, pointer, beat counter and flag logic
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        cnt_next      = cnt_reg;
        err_next      = err_reg;
        rd_valid_next = rd_valid_reg;
        if (rd_valid_reg && rd_ready) begin
            rd_valid_next = 1'b0;
        end
        if (rd_issue) begin
            rd_valid_next = 1'b1;
        end
        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    if (addr_ok) begin
                        ptr_next   = cmd_addr;
                        cnt_next   = cmd_len;
                        state_next = cmd_wr ? WRITE : READ;
                    end else begin
                        // Out-of-range command is swallowed and flagged
                        err_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    ptr_next = ptr_inc;
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    ptr_next = ptr_inc;
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rd_valid_reg && rd_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers and the registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cnt_reg      <= cnt_next;
            rd_valid_reg <= rd_valid_next;
            err_reg      <= err_next;
            if (rd_issue) begin
                rd_data_reg <= mem[ptr_reg];
            end
        end
    end

    // Storage words: each one captures a write beat addressed to it; never reset
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (!rst && wr_fire && (ptr_reg == ADDR_W'(gi))) begin
                mem[gi] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_dff_mem_burst.sv
// Directed bench for dff_mem_burst: a 16-word instance and a 12-word instance
// share stimulus, and sel chooses which one receives commands and is observed.
module tb_dff_mem_burst;

    logic       clk = 1'b0;
    logic       rst, sel;
    logic       cmd_valid, cmd_wr;
    logic [3:0] cmd_addr, cmd_len;
    logic       wr_valid, rd_ready;
    logic [7:0] wr_data;

    logic       cmd_ready_a, wr_ready_a, rd_valid_a, busy_a, err_a;
    logic [7:0] rd_data_a;
    logic       cmd_ready_b, wr_ready_b, rd_valid_b, busy_b, err_b;
    logic [7:0] rd_data_b;

    logic       cmd_ready_s, wr_ready_s, rd_valid_s, busy_s, err_s;
    logic [7:0] rd_data_s;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] wbuf  [16];
    logic [7:0] exp_q [16];

    always #5 clk = ~clk;

    assign cmd_ready_s = sel ? cmd_ready_b : cmd_ready_a;
    assign wr_ready_s  = sel ? wr_ready_b  : wr_ready_a;
    assign rd_valid_s  = sel ? rd_valid_b  : rd_valid_a;
    assign rd_data_s   = sel ? rd_data_b   : rd_data_a;
    assign busy_s      = sel ? busy_b      : busy_a;
    assign err_s       = sel ? err_b       : err_a;

    dff_mem_burst #(.DATA_W(8), .DEPTH(16), .LEN_W(4)) u16 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready_a),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_data(wr_data),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a),
        .busy(busy_a), .err(err_a)
    );

    dff_mem_burst #(.DATA_W(8), .DEPTH(12), .LEN_W(4)) u12 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready_b),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_data(wr_data),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b),
        .busy(busy_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) begin
            n_pass++;
            $display("check %s: %0h", tag, got);
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Offer a command and wait (bounded) until it is taken
    task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [3:0] len);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = cmd_ready_s;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("cmd_accept", {31'd0, acc}, 32'd1);
    endtask

    // Stream n write beats from wbuf, one per cycle
    task automatic write_beats(input int n);
        for (int i = 0; i < n; i++) begin
            check("wr_ready", {31'd0, wr_ready_s}, 32'd1);
            wr_valid = 1'b1;
            wr_data  = wbuf[i];
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    // Collect n read beats against exp_q; rd_ready follows the 4-cycle pattern pat
    task automatic read_beats(input int n, input logic [3:0] pat);
        int         got;
        int         k;
        logic       v, r, stall;
        logic [7:0] pd;
        got   = 0;
        k     = 0;
        stall = 1'b0;
        pd    = '0;
        check("rd_lat0", {31'd0, rd_valid_s}, 32'd0);
        while (got < n && k < 80) begin
            if (k == 1) check("rd_lat1", {31'd0, rd_valid_s}, 32'd1);
            if (stall) begin
                check("rd_hold_v", {31'd0, rd_valid_s}, 32'd1);
                check("rd_hold_d", {24'd0, rd_data_s}, {24'd0, pd});
            end
            if (rd_valid_s) check("rd_data", {24'd0, rd_data_s}, {24'd0, exp_q[got]});
            r        = pat[k % 4];
            rd_ready = r;
            v        = rd_valid_s;
            pd       = rd_data_s;
            stall    = v && !r;
            @(negedge clk);
            k++;
            if (v && r) got++;
        end
        rd_ready = 1'b0;
        check("rd_count", got, n);
        check("rd_busy_end", {31'd0, busy_s}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        check("rst_cmd_ready", {31'd0, cmd_ready_a}, 32'd1);
        check("rst_wr_ready",  {31'd0, wr_ready_a},  32'd0);
        check("rst_rd_valid",  {31'd0, rd_valid_a},  32'd0);
        check("rst_rd_data",   {24'd0, rd_data_a},   32'd0);
        check("rst_busy",      {31'd0, busy_a},      32'd0);
        check("rst_err",       {31'd0, err_a},       32'd0);
        check("rst_err12",     {31'd0, err_b},       32'd0);
        check("rst_cmd_rdy12", {31'd0, cmd_ready_b}, 32'd1);
        rst = 1'b0;

        // Fill every word with 80+i using a maximum-length burst
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h80 + 8'(i);
        send_cmd(1'b1, 4'd0, 4'd15);
        write_beats(16);

        // Write A0..A3 at 2, read back with rd_ready held high
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
        send_cmd(1'b1, 4'd2, 4'd3);
        write_beats(4);
        check("wr_done_busy", {31'd0, busy_s}, 32'd0);
        send_cmd(1'b0, 4'd2, 4'd3);
        exp_q[0] = 8'hA0; exp_q[1] = 8'hA1; exp_q[2] = 8'hA2; exp_q[3] = 8'hA3;
        read_beats(4, 4'b1111);

        // Wrapping burst at the top of a 16-word RAM
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
        send_cmd(1'b1, 4'd14, 4'd3);
        write_beats(4);
        send_cmd(1'b0, 4'd14, 4'd3);
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04;
        read_beats(4, 4'b1111);
        send_cmd(1'b0, 4'd0, 4'd1);
        exp_q[0] = 8'h03; exp_q[1] = 8'h04;
        read_beats(2, 4'b1111);

        // Read under toggling backpressure 1,0,0,1
        send_cmd(1'b0, 4'd2, 4'd3);
        exp_q[0] = 8'hA0; exp_q[1] = 8'hA1; exp_q[2] = 8'hA2; exp_q[3] = 8'hA3;
        read_beats(4, 4'b1001);

        // 12-word instance: wrapping write, then an out-of-range command
        sel = 1'b1;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        send_cmd(1'b1, 4'd10, 4'd3);
        write_beats(4);
        check("err12_before", {31'd0, err_s}, 32'd0);
        send_cmd(1'b1, 4'd13, 4'd3);
        check("err12_set",     {31'd0, err_s},       32'd1);
        check("err12_busy",    {31'd0, busy_s},      32'd0);
        check("err12_cmd_rdy", {31'd0, cmd_ready_s}, 32'd1);
        check("err12_wr_rdy",  {31'd0, wr_ready_s},  32'd0);
        wr_valid = 1'b1; wr_data = 8'hFF;
        repeat (2) @(negedge clk);
        wr_valid = 1'b0;
        send_cmd(1'b0, 4'd10, 4'd3);
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        read_beats(4, 4'b1101);
        check("err12_sticky", {31'd0, err_s}, 32'd1);
        sel = 1'b0;

        // Reset in the middle of a write burst at 8..11
        wbuf[0] = 8'h50; wbuf[1] = 8'h51; wbuf[2] = 8'h52; wbuf[3] = 8'h53;
        send_cmd(1'b1, 4'd8, 4'd3);
        write_beats(4);
        wbuf[0] = 8'h60; wbuf[1] = 8'h61;
        send_cmd(1'b1, 4'd8, 4'd3);
        write_beats(2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",    {31'd0, busy_s},      32'd0);
        check("mid_rst_cmd_rdy", {31'd0, cmd_ready_s}, 32'd1);
        check("mid_rst_wr_rdy",  {31'd0, wr_ready_s},  32'd0);
        check("mid_rst_err12",   {31'd0, err_b},       32'd0);
        rst = 1'b0;
        send_cmd(1'b0, 4'd8, 4'd3);
        exp_q[0] = 8'h60; exp_q[1] = 8'h61; exp_q[2] = 8'h52; exp_q[3] = 8'h53;
        read_beats(4, 4'b1111);

        // Reset with a read beat pending drops rd_valid
        send_cmd(1'b0, 4'd8, 4'd3);
        rd_ready = 1'b0;
        @(negedge clk);
        check("rd_pend_valid", {31'd0, rd_valid_s}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rd_rst_valid", {31'd0, rd_valid_s}, 32'd0);
        check("rd_rst_busy",  {31'd0, busy_s},     32'd0);
        check("rd_rst_data",  {24'd0, rd_data_s},  32'd0);
        rst = 1'b0;

        // Stray write beats in IDLE and during a read must not touch RAM
        wr_valid = 1'b1; wr_data = 8'hEE;
        repeat (2) @(negedge clk);
        send_cmd(1'b0, 4'd2, 4'd3);
        exp_q[0] = 8'hA0; exp_q[1] = 8'hA1; exp_q[2] = 8'hA2; exp_q[3] = 8'hA3;
        read_beats(4, 4'b1111);
        wr_valid = 1'b0;

        // Command held through a write burst is taken once, back in IDLE
        send_cmd(1'b1, 4'd12, 4'd1);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd12; cmd_len = 4'd1;
        check("hold_cmd_rdy0", {31'd0, cmd_ready_s}, 32'd0);
        check("hold_busy0",    {31'd0, busy_s},      32'd1);
        @(negedge clk);
        check("hold_cmd_rdy1", {31'd0, cmd_ready_s}, 32'd0);
        wr_valid = 1'b1; wr_data = 8'h70;
        @(negedge clk);
        wr_data = 8'h71;
        @(negedge clk);
        wr_valid = 1'b0;
        check("hold_cmd_idle", {31'd0, cmd_ready_s}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_rd_busy", {31'd0, busy_s}, 32'd1);
        exp_q[0] = 8'h70; exp_q[1] = 8'h71;
        read_beats(2, 4'b1111);

        // Full-RAM read-back with the maximum burst length
        exp_q = '{8'h03, 8'h04, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h86, 8'h87,
                  8'h60, 8'h61, 8'h52, 8'h53, 8'h70, 8'h71, 8'h01, 8'h02};
        send_cmd(1'b0, 4'd0, 4'd15);
        read_beats(16, 4'b0111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
